ac_motor_gate_guard: RTL and testbench
======================================

// Module: ac_motor_gate_guard
// PURPOSE
// - Protection stage that sits directly downstream of the three AC_MOTOR_SWITCH_DELAY instances and drives the gate pins.
// - Passes the six dead-timed gate signals through with one cycle of latency.
// - Blocks shoot-through, an external over-current fault and a stalled modulator.
// - Latches the fault cause, forces every gate off, and re-arms only after an explicit clear and a cooldown.
// PARAMETERS
// - CNT_W     16       width of the internal watchdog and cooldown counters
// - WDOG      50000    max cycles without any in_high edge while RUN before a watchdog fault
// - COOLDOWN  5000     cycles the gates stay off after an accepted clear
// PORTS
// - clk       in   1   system clock, single clock domain
// - reset     in   1   synchronous reset, active-high
// - enable    in   1   run request
// - fault_in  in   1   external over-current comparator, active-high
// - clear     in   1   fault acknowledge pulse
// - in_high   in   3   phase 1..3 high-side gate requests ([0] = phase 1)
// - in_low    in   3   phase 1..3 low-side gate requests
// - out_high  out  3   high-side gate drives
// - out_low   out  3   low-side gate drives
// - state     out  2   00 IDLE, 01 RUN, 10 FAULT, 11 COOLDOWN
// - fault_code out 2   00 none, 01 external, 10 shoot-through, 11 watchdog
// BEHAVIOUR
// - Clock, reset and registers
//   - One clock (clk); reset is synchronous and active-high; all state updates on the rising edge of clk.
//   - Every output is registered.
// - Reset values
//   - out_high = out_low = 3'b000.
//   - state = IDLE, fault_code = 00.
//   - Watchdog counter, cooldown counter and filter counter cleared.
// - IDLE: gates 0.
//   - -> RUN when enable = 1 and no fault condition is present this cycle.
// - RUN: out_high <= in_high and out_low <= in_low, giving 1-cycle latency.
//   - enable = 0 -> IDLE; gates 0 on the same edge.
// - Fault conditions, evaluated every cycle in RUN:
//   - external: fault_in asserted (after the filter, if compiled in).
//   - shoot-through: in_high[i] & in_low[i] for any i.
//   - watchdog: counter reaches WDOG with no in_high edge.
// - Fault entry from RUN: -> FAULT on the edge that samples the condition; that same edge loads gates with 0.
//   - An illegal high/low pair therefore never appears on the outputs.
// - fault_code priority when several conditions occur together: external > shoot-through > watchdog.
//   - fault_code holds until the clear is accepted.
// - Faults are also checked in IDLE (external only); an IDLE fault -> FAULT.
// - Watchdog counter
//   - Resets on any rising or falling edge of any in_high bit and on entry to RUN.
//   - Saturates at WDOG.
//   - Not counted outside RUN.
// - FAULT: gates 0.
//   - clear = 1 with the raw fault_in = 0 -> COOLDOWN; fault_code <= 00 on that edge.
//   - clear while fault_in = 1 is ignored.
// - COOLDOWN: gates 0; counter runs from 0.
//   - At COOLDOWN-1 -> RUN if enable = 1, else -> IDLE.
//   - An external fault during COOLDOWN -> FAULT with code 01; the counter restarts at the next clear.
// - enable = 0 in FAULT or COOLDOWN has no effect on the state sequence.
// - Counter widths: WDOG and COOLDOWN must be < 2**CNT_W; the counters never wrap.
// CONFIGURATION
// - Macro AC_MOTOR_GATE_GUARD_FILTER_EN, defined:
//   - fault_in must be 1 for 3 consecutive cycles before an external fault is raised.
//   - External fault latency becomes 3 edges.
//   - A single low sample resets the filter count.
// - Undefined:
//   - A single-cycle fault_in = 1 raises the external fault on the next edge.
// - Shoot-through and watchdog detection are unaffected by the macro.
// TESTING
// - Pass-through: reset, enable = 1, in_high = 001, in_low = 010.
//   - Next edge: state = 01; following edge: out_high = 001, out_low = 010.
// - Shoot-through: in RUN, in_high = 010 and in_low = 010 for one cycle.
//   - Same edge: out_high = out_low = 000, state = 10, fault_code = 10.
//   - Then clear = 1 with fault_in = 0: state = 11 for COOLDOWN cycles, then 01.
// - External fault pulse, 1 cycle: without the macro, fault_code = 01; with the macro, ignored.
//   - A 3-cycle pulse trips fault_code = 01 in both builds.
// - Watchdog: in RUN, hold in_high constant. Fault at exactly WDOG cycles (use WDOG = 20): fault_code = 11.
//   - Toggling in_high every 10 cycles never trips.
// - Clear rejected: in FAULT, clear = 1 with fault_in = 1. State stays 10 and fault_code is unchanged.
// - Reset mid-fault: in FAULT, assert reset for one cycle.
//   - state = 00, fault_code = 00, all gates 0.
//   - With enable = 1, RUN resumes on the edge after reset is released.

Source files
------------

// File: rtl/ac_motor_gate_guard.sv
// ac_motor_gate_guard: protection stage between the three switch-delay
// instances and the gate pins. It passes the six gate requests through with
// one cycle of latency. It forces every gate off on shoot-through, on an
// external over-current, or on a stalled modulator (watchdog). The fault
// cause is latched. The stage re-arms only after a clear and a cooldown.
// Optional build macro: AC_MOTOR_GATE_GUARD_FILTER_EN. When it is defined,
// fault_in must be high for 3 consecutive cycles before an external fault
// is raised.
`timescale 1ns/1ps
module ac_motor_gate_guard #(
  parameter int CNT_W    = 16,
  parameter int WDOG     = 50000,
  parameter int COOLDOWN = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       fault_in,
  input  logic       clear,
  input  logic [2:0] in_high,
  input  logic [2:0] in_low,
  output logic [2:0] out_high,
  output logic [2:0] out_low,
  output logic [1:0] state,
  output logic [1:0] fault_code
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_FAULT = 2'b10;
  localparam logic [1:0] S_COOL  = 2'b11;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_EXT   = 2'b01;
  localparam logic [1:0] FC_SHOOT = 2'b10;
  localparam logic [1:0] FC_WDOG  = 2'b11;

  localparam logic [CNT_W-1:0] WDOG_C    = CNT_W'(WDOG);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       r_state;
  logic [1:0]       r_fault_code;
  logic [2:0]       r_out_high;
  logic [2:0]       r_out_low;
  logic [2:0]       r_prev_high;
  logic [CNT_W-1:0] r_wdog_cnt;
  logic [CNT_W-1:0] r_cool_cnt;

  logic             w_ext;
  logic             w_shoot;
  logic             w_hi_edge;
  logic             w_wdog;
  logic [CNT_W-1:0] w_wdog_inc;

`ifdef AC_MOTOR_GATE_GUARD_FILTER_EN
  logic [1:0] r_filt_cnt;

  // Count consecutive high samples of fault_in (saturating at 2); any low sample restarts it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_filt_cnt <= 2'd0;
    end else if (!fault_in) begin
      r_filt_cnt <= 2'd0;
    end else if (r_filt_cnt != 2'd2) begin
      r_filt_cnt <= r_filt_cnt + 2'd1;
    end
  end

  // Third consecutive high sample raises the external fault
  assign w_ext = fault_in && (r_filt_cnt == 2'd2);
`else
  assign w_ext = fault_in;
`endif

  assign w_shoot    = |(in_high & in_low);
  assign w_hi_edge  = (in_high != r_prev_high);
  // Saturating increment so the counter can never wrap
  assign w_wdog_inc = (r_wdog_cnt == WDOG_C) ? r_wdog_cnt : (r_wdog_cnt + CNT_ONE);
  // Trip on the edge where the stall count would reach WDOG
  assign w_wdog     = !w_hi_edge && (w_wdog_inc == WDOG_C);

  // Protection FSM: gate registers, fault latch, watchdog and cooldown counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_fault_code <= FC_NONE;
      r_out_high   <= 3'b000;
      r_out_low    <= 3'b000;
      r_prev_high  <= 3'b000;
      r_wdog_cnt   <= '0;
      r_cool_cnt   <= '0;
    end else begin
      r_prev_high <= in_high;
      // Gates are off unless RUN continues through this edge
      r_out_high  <= 3'b000;
      r_out_low   <= 3'b000;
      case (r_state)
        S_IDLE: begin
          if (w_ext) begin
            r_state      <= S_FAULT;
            r_fault_code <= FC_EXT;
          end else if (enable) begin
            r_state    <= S_RUN;
            r_wdog_cnt <= '0;
          end
        end
        S_RUN: begin
          // A fault wins over a simultaneous enable drop so the cause is kept
          if (w_ext || w_shoot || w_wdog) begin
            r_state      <= S_FAULT;
            r_fault_code <= w_ext ? FC_EXT : (w_shoot ? FC_SHOOT : FC_WDOG);
          end else if (!enable) begin
            r_state <= S_IDLE;
          end else begin
            r_out_high <= in_high;
            r_out_low  <= in_low;
            r_wdog_cnt <= w_hi_edge ? '0 : w_wdog_inc;
          end
        end
        S_FAULT: begin
          // The raw comparator must be quiet for a clear to be accepted
          if (clear && !fault_in) begin
            r_state      <= S_COOL;
            r_fault_code <= FC_NONE;
            r_cool_cnt   <= '0;
          end
        end
        S_COOL: begin
          if (w_ext) begin
            r_state      <= S_FAULT;
            r_fault_code <= FC_EXT;
          end else if (r_cool_cnt == COOL_LAST) begin
            r_state    <= enable ? S_RUN : S_IDLE;
            r_wdog_cnt <= '0;
          end else begin
            r_cool_cnt <= r_cool_cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

  assign out_high   = r_out_high;
  assign out_low    = r_out_low;
  assign state      = r_state;
  assign fault_code = r_fault_code;

endmodule

// File: tb/tb_ac_motor_gate_guard.sv
// Testbench for ac_motor_gate_guard. It runs directed scenarios first and
// then randomized traffic. Every cycle is compared against a timestamp-based
// behavioural model. Honors AC_MOTOR_GATE_GUARD_FILTER_EN when defined.
`timescale 1ns/1ps
module tb_ac_motor_gate_guard;

  localparam int CNT_W    = 16;
  localparam int WDOG     = 20;
  localparam int COOLDOWN = 8;
`ifdef AC_MOTOR_GATE_GUARD_FILTER_EN
  localparam int FILT_N = 3;
`else
  localparam int FILT_N = 1;
`endif

  logic       clk = 1'b0;
  logic       reset, enable, fault_in, clear;
  logic [2:0] in_high, in_low, out_high, out_low;
  logic [1:0] state, fault_code;

  int n_checks = 0;
  int n_errors = 0;

  // model state: mode/cause plus event timestamps in cycle units
  logic [1:0] m_state, m_code;
  logic [2:0] m_oh, m_ol, m_prev;
  int         m_fault_run, m_last, m_cool_start, n_cyc;

  always #5 clk = ~clk;

  ac_motor_gate_guard #(
    .CNT_W(CNT_W), .WDOG(WDOG), .COOLDOWN(COOLDOWN)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .fault_in(fault_in), .clear(clear),
    .in_high(in_high), .in_low(in_low), .out_high(out_high), .out_low(out_low),
    .state(state), .fault_code(fault_code)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Behavioural reference: one call per rising edge, using the sampled inputs
  task automatic model_step();
    bit ext, shoot, hedge, wd;
    logic [1:0] ns;
    logic [2:0] noh, nol;
    n_cyc++;
    if (reset) begin
      m_state = 2'd0; m_code = 2'd0; m_oh = 3'd0; m_ol = 3'd0;
      m_prev = 3'd0; m_fault_run = 0;
    end else begin
      m_fault_run = fault_in ? m_fault_run + 1 : 0;
      ext   = (m_fault_run >= FILT_N);
      shoot = ((in_high & in_low) != 3'd0);
      hedge = (in_high != m_prev);
      ns = m_state; noh = 3'd0; nol = 3'd0;
      if (m_state == 2'd0) begin
        if (ext) begin ns = 2'd2; m_code = 2'd1; end
        else if (enable) begin ns = 2'd1; m_last = n_cyc; end
      end else if (m_state == 2'd1) begin
        wd = !hedge && ((n_cyc - m_last) >= WDOG);
        if (ext || shoot || wd) begin
          ns = 2'd2;
          m_code = ext ? 2'd1 : (shoot ? 2'd2 : 2'd3);
        end else if (!enable) begin
          ns = 2'd0;
        end else begin
          noh = in_high; nol = in_low;
          if (hedge) m_last = n_cyc;
        end
      end else if (m_state == 2'd2) begin
        if (clear && !fault_in) begin ns = 2'd3; m_code = 2'd0; m_cool_start = n_cyc; end
      end else begin
        if (ext) begin ns = 2'd2; m_code = 2'd1; end
        else if ((n_cyc - m_cool_start) >= COOLDOWN) begin
          ns = enable ? 2'd1 : 2'd0;
          m_last = n_cyc;
        end
      end
      m_state = ns; m_oh = noh; m_ol = nol;
      m_prev = in_high;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("state", 8'(state), 8'(m_state));
    check_eq("fault_code", 8'(fault_code), 8'(m_code));
    check_eq("out_high", 8'(out_high), 8'(m_oh));
    check_eq("out_low", 8'(out_low), 8'(m_ol));
  endtask

  // clear any fault and ride through the cooldown, toggling in_high so RUN stays live
  task automatic recover();
    clear = 1'b1; fault_in = 1'b0; in_low = 3'd0; in_high = in_high ^ 3'b001;
    tick();
    clear = 1'b0;
    for (int i = 0; i < COOLDOWN; i++) begin
      in_high = in_high ^ 3'b001;
      tick();
    end
  endtask

  initial begin
    int burst, hold;
    n_cyc = 0; m_last = 0; m_cool_start = 0; m_fault_run = 0;
    m_state = 2'd0; m_code = 2'd0; m_oh = 3'd0; m_ol = 3'd0; m_prev = 3'd0;
    reset = 1'b1; enable = 1'b0; fault_in = 1'b0; clear = 1'b0;
    in_high = 3'd0; in_low = 3'd0;

    // reset values
    tick(); tick();
    check_eq("rst_state", 8'(state), 8'd0);
    check_eq("rst_code", 8'(fault_code), 8'd0);
    check_eq("rst_gates", 8'({out_high, out_low}), 8'd0);
    $display("[%0t] reset: state=%0d code=%0d", $time, state, fault_code);

    // pass-through with one cycle of latency
    reset = 1'b0; enable = 1'b1; in_high = 3'b001; in_low = 3'b010;
    tick();
    check_eq("pt_state", 8'(state), 8'd1);
    tick();
    check_eq("pt_high", 8'(out_high), 8'h01);
    check_eq("pt_low", 8'(out_low), 8'h02);
    $display("[%0t] pass-through: high=%b low=%b", $time, out_high, out_low);

    // shoot-through, then clear and cooldown
    in_high = 3'b010; in_low = 3'b010;
    tick();
    check_eq("st_state", 8'(state), 8'd2);
    check_eq("st_code", 8'(fault_code), 8'd2);
    check_eq("st_gates", 8'({out_high, out_low}), 8'd0);
    in_high = 3'd0; in_low = 3'd0; clear = 1'b1;
    tick();
    check_eq("st_clear", 8'(state), 8'd3);
    clear = 1'b0;
    for (int i = 1; i <= COOLDOWN; i++) begin
      tick();
      check_eq("cool_seq", 8'(state), (i < COOLDOWN) ? 8'd3 : 8'd1);
    end
    $display("[%0t] shoot-through + cooldown: state=%0d", $time, state);

    // one-cycle external pulse: trips only without the filter
    fault_in = 1'b1;
    tick();
    fault_in = 1'b0;
    check_eq("ext1_state", 8'(state), (FILT_N == 1) ? 8'd2 : 8'd1);
    check_eq("ext1_code", 8'(fault_code), (FILT_N == 1) ? 8'd1 : 8'd0);
    recover();
    check_eq("ext1_recover", 8'(state), 8'd1);
    $display("[%0t] ext 1-cycle pulse: state=%0d", $time, state);

    // three-cycle pulse trips in both builds
    fault_in = 1'b1;
    tick(); tick(); tick();
    check_eq("ext3_state", 8'(state), 8'd2);
    check_eq("ext3_code", 8'(fault_code), 8'd1);
    $display("[%0t] ext 3-cycle pulse: code=%0d", $time, fault_code);

    // clear rejected while the comparator is still high
    clear = 1'b1;
    tick();
    check_eq("clr_rej_state", 8'(state), 8'd2);
    check_eq("clr_rej_code", 8'(fault_code), 8'd1);
    recover();
    check_eq("clr_ok", 8'(state), 8'd1);
    $display("[%0t] clear rejected then accepted: state=%0d", $time, state);

    // watchdog: hold in_high, trip at exactly WDOG cycles
    for (int i = 1; i <= WDOG; i++) begin
      tick();
      check_eq("wdog_seq", 8'(state), (i == WDOG) ? 8'd2 : 8'd1);
    end
    check_eq("wdog_code", 8'(fault_code), 8'd3);
    $display("[%0t] watchdog: code=%0d", $time, fault_code);

    // toggling every 10 cycles never trips
    recover();
    for (int i = 0; i < 60; i++) begin
      if (i % 10 == 0) in_high = in_high ^ 3'b100;
      tick();
    end
    check_eq("wdog_toggle", 8'(state), 8'd1);
    $display("[%0t] watchdog toggling: state=%0d", $time, state);

    // reset in the middle of a fault
    in_high = 3'b100; in_low = 3'b100;
    tick();
    check_eq("mid_fault", 8'(state), 8'd2);
    reset = 1'b1; in_low = 3'd0;
    tick();
    check_eq("mid_rst_state", 8'(state), 8'd0);
    check_eq("mid_rst_code", 8'(fault_code), 8'd0);
    check_eq("mid_rst_gates", 8'({out_high, out_low}), 8'd0);
    reset = 1'b0; enable = 1'b1;
    tick();
    check_eq("mid_rst_run", 8'(state), 8'd1);
    $display("[%0t] reset mid-fault: state=%0d", $time, state);

    // randomized traffic against the model
    burst = 0; hold = 0;
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 499) == 0);
      enable = ($urandom_range(0, 19) != 0);
      if (burst > 0) begin
        fault_in = 1'b1; burst--;
      end else if ($urandom_range(0, 79) == 0) begin
        fault_in = 1'b1; burst = $urandom_range(0, 4);
      end else begin
        fault_in = 1'b0;
      end
      clear = ($urandom_range(0, 9) == 0);
      if (hold > 0) hold--;
      else begin
        in_high = 3'($urandom);
        hold = $urandom_range(0, 30);
      end
      in_low = ($urandom_range(0, 49) == 0) ? in_high : (~in_high & 3'($urandom));
      tick();
    end
    $display("[%0t] random traffic: 3000 cycles", $time);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
